store_queue: RTL and testbench

- Store queue between the MEM-stage request interface and the data memory port.
- Buffers stores in a FIFO and drains them one at a time, each as a two-cycle write to memory.
- Loads go to memory immediately when no buffered store targets the same word. Otherwise the pipeline is held until the conflicting stores have drained.
- Load data is not routed through this block; it returns directly from memory.

---
 rtl/store_queue.sv | 170 +++++++++++++++++
 tb/tb_store_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/store_queue.sv
// Store queue: buffers CPU stores in a FIFO and drains each one as a two-cycle
// memory write, letting non-conflicting loads bypass while the drain is idle.
module store_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_write,
  input  logic        req_read,
  input  logic [3:0]  req_sign_mask,
  input  logic        mem_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  output logic [3:0]  mem_sign_mask,
  output logic        cpu_stall,
  output logic        sq_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]      r_addr  [DEPTH];
  logic [31:0]      r_wdata [DEPTH];
  logic [3:0]       r_mask  [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_starve;
  logic [IDX_W-1:0] r_inflight_idx;

  logic [IDX_W-1:0] w_req_idx;
  logic [PTR_W-1:0] w_off [DEPTH];
  logic             w_hit_q;
  logic             w_hazard;
  logic             w_full;
  logic             w_pop;
  logic             w_enq;
  logic             w_force;
  logic             w_load_go;
  logic             w_drain_go;

  assign w_req_idx = req_addr[IDX_W+1:2];
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = (r_state == ST_ISSUE);
  assign w_enq     = req_write & (~w_full | w_pop);
  assign w_force   = (r_starve == STARVE_MAX);

  // Compare the load's word index against every occupied FIFO slot
  always_comb begin
    w_hit_q = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off[i] = PTR_W'(i) - r_head;
      w_hit_q  = w_hit_q | (({1'b0, w_off[i]} < r_count) &&
                            (r_addr[i][IDX_W+1:2] == w_req_idx));
    end
  end

  // The head stays in the FIFO during ISSUE, so only WAIT needs the captured index
  assign w_hazard   = w_hit_q | ((r_state == ST_WAIT) && (r_inflight_idx == w_req_idx));
  assign w_load_go  = req_read & ~req_write & ~w_hazard & (r_state == ST_IDLE) &
                      ~mem_stall & ~w_force;
  assign w_drain_go = (r_state == ST_IDLE) && (r_count != CNT_W'(0)) &&
                      !w_load_go && !mem_stall;

  // Drain FSM next-state
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_state_nxt = w_drain_go ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  w_state_nxt = mem_stall ? ST_WAIT : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Control state: FSM, pointers, occupancy, starvation and in-flight index
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_head         <= PTR_W'(0);
      r_tail         <= PTR_W'(0);
      r_count        <= CNT_W'(0);
      r_starve       <= CNT_W'(0);
      r_inflight_idx <= IDX_W'(0);
    end else begin
      r_state <= w_state_nxt;
      if (w_enq) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head         <= r_head + PTR_W'(1);
        r_inflight_idx <= r_addr[r_head][IDX_W+1:2];
      end
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // Loads beating a pending drain are counted; saturation forces the drain
      if ((r_count == CNT_W'(0)) || w_drain_go) begin
        r_starve <= CNT_W'(0);
      end else if (w_load_go && !w_force) begin
        r_starve <= r_starve + CNT_W'(1);
      end
    end
  end

  // FIFO payload storage
  always_ff @(posedge clk) begin
    if (!reset && w_enq) begin
      r_addr[r_tail]  <= req_addr;
      r_wdata[r_tail] <= req_wdata;
      r_mask[r_tail]  <= req_sign_mask;
    end
  end

  // Memory port, pipeline stall and empty flag
  always_comb begin
    mem_addr      = 32'h0;
    mem_wdata     = 32'h0;
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    mem_sign_mask = 4'h0;
    cpu_stall     = 1'b0;
    sq_empty      = 1'b1;
    if (reset) begin
      sq_empty = 1'b1;
    end else begin
      sq_empty = (r_count == CNT_W'(0)) && (r_state == ST_IDLE);
      if (r_state == ST_ISSUE) begin
        mem_write     = 1'b1;
        mem_addr      = r_addr[r_head];
        mem_wdata     = r_wdata[r_head];
        mem_sign_mask = r_mask[r_head];
      end else if (w_load_go) begin
        mem_read      = 1'b1;
        mem_addr      = req_addr;
        mem_sign_mask = req_sign_mask;
      end else begin
        mem_write = 1'b0;
        mem_read  = 1'b0;
      end
      // A combined read+write is handled purely as a store
      if (req_write) begin
        cpu_stall = ~w_enq;
      end else if (req_read) begin
        cpu_stall = ~w_load_go;
      end else begin
        cpu_stall = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Randomized and directed bench for store_queue, checked every cycle against a
// queue-based behavioural model of the store buffer and a one-cycle-stall memory.
module tb_store_queue;

  localparam int DEPTH = 4;
  localparam int IDX_W = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_write;
  logic        req_read;
  logic [3:0]  req_sign_mask;
  logic        mem_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [3:0]  mem_sign_mask;
  logic        cpu_stall;
  logic        sq_empty;

  always #5 clk = ~clk;

  store_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
    .req_read(req_read), .req_sign_mask(req_sign_mask), .mem_stall(mem_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_sign_mask(mem_sign_mask),
    .cpu_stall(cpu_stall), .sq_empty(sq_empty)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } st_t;

  // Reference model: pending stores, drain phase (0 idle, 1 writing, 2 waiting)
  st_t              mq[$];
  int               phase = 0;
  logic [IDX_W-1:0] fl_idx = '0;
  int               starve = 0;
  logic             last_wr = 1'b0;
  int               total = 0;
  int               bad = 0;
  int               n_written = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m, input logic extra_stall,
                       output logic stalled);
    logic        e_w, e_r, e_st, e_emp, stall_now, pop, enq, hz, lgo, dgo, was_empty;
    logic [31:0] e_a, e_d;
    logic [3:0]  e_m;
    st_t         ent;
    reset = rst; req_write = w; req_read = r; req_addr = a; req_wdata = d;
    req_sign_mask = m;
    stall_now = last_wr | extra_stall;
    mem_stall = stall_now;
    @(negedge clk);
    e_w = 1'b0; e_r = 1'b0; e_st = 1'b0; e_emp = 1'b1;
    e_a = 32'h0; e_d = 32'h0; e_m = 4'h0;
    if (rst) begin
      mq.delete();
      phase = 0; starve = 0; fl_idx = '0;
    end else begin
      pop = (phase == 1);
      enq = w && ((mq.size() < DEPTH) || pop);
      hz = 1'b0;
      foreach (mq[k]) if (mq[k].a[IDX_W+1:2] == a[IDX_W+1:2]) hz = 1'b1;
      if (phase == 2 && fl_idx == a[IDX_W+1:2]) hz = 1'b1;
      lgo = r && !w && !hz && (phase == 0) && !stall_now && (starve < DEPTH - 1);
      dgo = (phase == 0) && (mq.size() > 0) && !lgo && !stall_now;
      e_emp = (mq.size() == 0) && (phase == 0);
      if (phase == 1) begin
        e_w = 1'b1; e_a = mq[0].a; e_d = mq[0].d; e_m = mq[0].m;
      end else if (lgo) begin
        e_r = 1'b1; e_a = a; e_m = m;
      end
      e_st = w ? !enq : (r ? !lgo : 1'b0);
      was_empty = (mq.size() == 0);
      if (pop) begin
        fl_idx = mq[0].a[IDX_W+1:2];
        void'(mq.pop_front());
        n_written++;
      end
      if (enq) begin
        ent.a = a; ent.d = d; ent.m = m;
        mq.push_back(ent);
      end
      if (was_empty || dgo) starve = 0;
      else if (lgo && starve < DEPTH - 1) starve++;
      case (phase)
        0:       phase = dgo ? 1 : 0;
        1:       phase = 2;
        default: phase = stall_now ? 2 : 0;
      endcase
    end
    check("mem_write", 32'(mem_write), 32'(e_w));
    check("mem_read", 32'(mem_read), 32'(e_r));
    check("mem_addr", mem_addr, e_a);
    check("mem_wdata", mem_wdata, e_d);
    check("mem_sign_mask", 32'(mem_sign_mask), 32'(e_m));
    check("cpu_stall", 32'(cpu_stall), 32'(e_st));
    check("sq_empty", 32'(sq_empty), 32'(e_emp));
    last_wr = e_w;
    stalled = e_st;
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted, as the MEM stage would
  task automatic issue(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    logic s;
    int   n;
    n = 0;
    do begin
      cycle(1'b0, w, r, a, d, m, 1'b0, s);
      n++;
    end while (s && n < 50);
    if (s) check("req_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    logic s;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, s);
  endtask

  initial begin
    logic        s, rst, w, r, xs;
    logic [31:0] a;
    int          op, n, wr_before;
    req_write = 1'b0; req_read = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_sign_mask = 4'h0; mem_stall = 1'b0; reset = 1'b1;

    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, s);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, s);

    issue(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'b0010);
    idle(5);

    for (int k = 0; k < 5; k++) issue(1'b1, 1'b0, 32'h100 + 32'(k * 4), 32'hA000 + 32'(k), 4'h2);
    idle(20);

    issue(1'b1, 1'b0, 32'h20, 32'h1111, 4'h2);
    issue(1'b0, 1'b1, 32'h22, 32'h0, 4'h1);
    idle(5);

    issue(1'b1, 1'b0, 32'h20, 32'h2222, 4'h2);
    issue(1'b0, 1'b1, 32'h40, 32'h0, 4'h2);
    idle(6);

    // Fill the queue, then hammer it with non-conflicting loads
    wr_before = n_written;
    for (int k = 0; k < 6; k++) issue(1'b1, 1'b0, 32'h200 + 32'(k * 4), 32'hB000 + 32'(k), 4'h2);
    for (int k = 0; k < 10; k++) issue(1'b0, 1'b1, 32'h300 + 32'(k * 4), 32'h0, 4'h2);
    check("drain_progress", 32'(n_written > wr_before + 1), 32'd1);
    for (int k = 0; k < 12; k++) issue(1'b1, 1'b0, 32'h400 + 32'(k * 4), 32'hC000 + 32'(k), 4'h4);
    idle(40);

    // Reset while a store sits in WAIT with two more queued
    for (int k = 0; k < 3; k++) issue(1'b1, 1'b0, 32'h500 + 32'(k * 4), 32'hD000 + 32'(k), 4'h2);
    n = 0;
    while (phase != 2 && n < 20) begin
      idle(1);
      n++;
    end
    check("reach_wait", 32'(phase), 32'd2);
    check("queued_before_reset", 32'(mq.size()), 32'd2);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, s);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      op  = $urandom_range(0, 19);
      w   = (op < 8) || (op == 19);
      r   = (op >= 8 && op < 16) || (op == 19);
      a   = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)) |
            (32'($urandom_range(0, 1)) << 20);
      xs  = ($urandom_range(0, 9) == 0);
      cycle(rst, w, r, a, $urandom, 4'($urandom_range(0, 15)), xs, s);
    end
    idle(40);
    check("final_empty", 32'(sq_empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
